div_seq: RTL and testbench



---
 rtl/div_seq.sv | 103 ++++++++++
 tb/tb_div_seq.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// Sequential unsigned 16-bit divider: repeated subtraction of the divisor from the dividend.
// Operands arrive one per cycle on data_in; results are held with done until start drops.
module div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] data_in,
  output logic        req_a,
  output logic        req_b,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [15:0] quotient,
  output logic [15:0] remainder
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    CALC   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] a_reg, b_reg, r_reg, q_reg;
  logic        div_zero_reg;
  logic        ge_b, z_b;

  assign ge_b = (r_reg >= b_reg);
  assign z_b  = (b_reg == 16'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    req_a      = 1'b0;
    req_b      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_reg)
      IDLE:   if (start) state_next = LOAD_A;
      LOAD_A: begin
        req_a      = 1'b1;
        busy       = 1'b1;
        state_next = LOAD_B;
      end
      LOAD_B: begin
        req_b      = 1'b1;
        busy       = 1'b1;
        state_next = CALC;
      end
      CALC: begin
        busy = 1'b1;
        // Zero divisor is tested first so the subtract loop never runs with B = 0.
        if (z_b || !ge_b) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (!start) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg        <= 16'd0;
      b_reg        <= 16'd0;
      r_reg        <= 16'd0;
      q_reg        <= 16'd0;
      div_zero_reg <= 1'b0;
    end else begin
      case (state_reg)
        LOAD_A: a_reg <= data_in;
        LOAD_B: begin
          b_reg        <= data_in;
          r_reg        <= a_reg;
          q_reg        <= 16'd0;
          div_zero_reg <= 1'b0;
        end
        CALC: begin
          if (z_b) begin
            div_zero_reg <= 1'b1;
            q_reg        <= 16'd0;
          end else if (ge_b) begin
            r_reg <= r_reg - b_reg;
            q_reg <= q_reg + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign quotient  = q_reg;
  assign remainder = r_reg;
  assign div_zero  = div_zero_reg;

endmodule

// File: tb/tb_div_seq.sv
// Testbench for div_seq: directed cases plus random operands checked against a
// quotient/remainder model built from the / and % operators.
module tb_div_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] data_in;
  logic        req_a, req_b, busy, done, div_zero;
  logic [15:0] quotient, remainder;

  int errors = 0;
  int checks = 0;

  div_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .data_in  (data_in),
    .req_a    (req_a),
    .req_b    (req_b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .quotient (quotient),
    .remainder(remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_a"}, {31'd0, req_a}, 32'd0);
    chk({tag, "_req_b"}, {31'd0, req_b}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_dz"}, {31'd0, div_zero}, 32'd0);
    chk({tag, "_q"}, {16'd0, quotient}, 32'd0);
    chk({tag, "_r"}, {16'd0, remainder}, 32'd0);
  endtask

  // Runs one division from IDLE (called at a negedge); returns at the negedge
  // where done is first seen (or the cycle budget ran out).
  task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input bit drop_start);
    logic [15:0] exp_q, exp_r;
    logic        exp_dz;
    int          exp_lat, e;
    if (bv == 16'd0) begin
      exp_q = 16'd0; exp_r = av; exp_dz = 1'b1; exp_lat = 3;
    end else begin
      exp_q = av / bv; exp_r = av % bv; exp_dz = 1'b0; exp_lat = 3 + int'(av / bv);
    end
    start = 1'b1;
    @(posedge clk); e = 0; @(negedge clk);
    chk("req_a", {31'd0, req_a}, 32'd1);
    data_in = av;
    @(posedge clk); e = 1; @(negedge clk);
    chk("req_b", {31'd0, req_b}, 32'd1);
    data_in = bv;
    if (drop_start) start = 1'b0;
    @(posedge clk); e = 2; @(negedge clk);
    while (!done && e < 70000) begin
      chk("busy_calc", {31'd0, busy}, 32'd1);
      @(posedge clk); e++; @(negedge clk);
    end
    chk("done", {31'd0, done}, 32'd1);
    chk("latency", e, exp_lat);
    chk("quotient", {16'd0, quotient}, {16'd0, exp_q});
    chk("remainder", {16'd0, remainder}, {16'd0, exp_r});
    chk("div_zero", {31'd0, div_zero}, {31'd0, exp_dz});
    $display("op %0d / %0d: q=%0d r=%0d dz=%0d edges=%0d", av, bv, quotient, remainder, div_zero, e);
  endtask

  task automatic release_start();
    start = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("release_done", {31'd0, done}, 32'd0);
    chk("release_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [15:0] ra, rb;
    rst = 1'b1; start = 1'b0; data_in = 16'd0;
    #3;
    chk_all_zero("reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    chk_all_zero("post_reset");

    // 15 / 4 with start held: done must persist
    run_op(16'd15, 16'd4, 1'b0);
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      chk("done_held", {31'd0, done}, 32'd1);
      chk("q_held", {16'd0, quotient}, 32'd3);
    end
    release_start();

    run_op(16'd9, 16'd9, 1'b0);
    release_start();
    run_op(16'd5, 16'd9, 1'b0);
    release_start();
    run_op(16'd0, 16'd3, 1'b0);
    release_start();

    run_op(16'd100, 16'd0, 1'b0);
    release_start();
    run_op(16'd100, 16'd7, 1'b0);
    release_start();

    run_op(16'd65535, 16'd1, 1'b0);
    release_start();

    // Reset in the middle of 1000 / 3
    start = 1'b1;
    @(posedge clk); @(negedge clk); data_in = 16'd1000;
    @(posedge clk); @(negedge clk); data_in = 16'd3;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    start = 1'b0;
    rst = 1'b1;
    #1;
    chk_all_zero("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    chk_all_zero("after_reset");
    run_op(16'd1000, 16'd3, 1'b0);
    release_start();

    // start dropped during the operation: one-cycle done pulse
    run_op(16'd20, 16'd6, 1'b1);
    @(posedge clk); @(negedge clk);
    chk("pulse_done", {31'd0, done}, 32'd0);
    chk("pulse_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      ra = 16'($urandom);
      rb = (i == 9) ? 16'd0 : 16'($urandom_range(64, 65535));
      run_op(ra, rb, i[0]);
      release_start();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
